clock_ctrl_12h: RTL and testbench

Sequencing controller for the 12-hour clock datapath: the seconds, minutes and 01–12 hour BCD counters.
- Generates the 1 Hz tick and chains counter enables from the counters' carry outputs.
- Runs a RUN / SET_HR / SET_MIN mode FSM driven by front-panel button pulses.
- Tracks AM/PM and produces display blink qualifiers for the field being set.
- Sits between the debounced button logic and the counter datapath.

---
 rtl/clock_pkg.sv | 24 ++
 rtl/tick_prescaler.sv | 35 +++
 rtl/clock_ctrl_12h.sv | 95 +++++++++
 tb/tb_clock_ctrl_12h.sv | 265 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/clock_pkg.sv
// Shared definitions for the 12-hour clock sequencing logic: mode encodings
// and the BCD hour value at which AM/PM flips.
package clock_pkg;

  typedef enum logic [1:0] {
    MODE_RUN     = 2'b00,
    MODE_SET_HR  = 2'b01,
    MODE_SET_MIN = 2'b10
  } mode_e;

  typedef struct packed {
    logic [3:0] tens;
    logic [3:0] ones;
  } bcd_hour_t;

  localparam bcd_hour_t HOUR_11 = '{tens: 4'd1, ones: 4'd1};

  // True when the hour counter currently shows 11, i.e. the next hour
  // increment crosses into 12 and flips AM/PM.
  function automatic logic is_hour_11(input logic [3:0] tens, input logic [3:0] ones);
    return (tens == HOUR_11.tens) && (ones == HOUR_11.ones);
  endfunction

endpackage

// File: rtl/tick_prescaler.sv
// Free-running divide-by-CLK_HZ prescaler. Produces a one-cycle 1 Hz tick on
// the last count and a half-second phase used for display blinking.
module tick_prescaler #(
  parameter int CLK_HZ = 50_000_000
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  output logic tick,
  output logic phase
);

  localparam int              W    = (CLK_HZ > 1) ? $clog2(CLK_HZ) : 1;
  localparam logic [W-1:0]    LAST = W'(CLK_HZ - 1);
  localparam logic [W-1:0]    HALF = W'(CLK_HZ / 2);

  logic [W-1:0] count;

  // Count 0..CLK_HZ-1 and wrap; clr restarts a full second from zero.
  always_ff @(posedge clk) begin
    // NOTE: registered state uses non-blocking assignments so every flop
    // samples the pre-edge values regardless of statement order.
    if (rst || clr) begin
      count <= '0;
    end else if (count == LAST) begin
      count <= '0;
    end else begin
      count <= count + W'(1);
    end
  end

  assign tick  = (count == LAST);
  assign phase = (count < HALF);

endmodule

// File: rtl/clock_ctrl_12h.sv
// Sequencing controller for the 12-hour clock: owns the 1 Hz prescaler, the
// RUN/SET_HR/SET_MIN mode FSM, counter enable chaining, AM/PM and blinking.
module clock_ctrl_12h #(
  parameter int CLK_HZ = 50_000_000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       btn_mode,
  input  logic       btn_inc,
  input  logic       sec_carry,
  input  logic       min_carry,
  input  logic [3:0] hr_tens,
  input  logic [3:0] hr_ones,
  output logic       sec_en,
  output logic       sec_clr,
  output logic       min_en,
  output logic       hour_en,
  output logic       pm,
  output logic [1:0] mode,
  output logic       blink_hr,
  output logic       blink_min
);

  import clock_pkg::*;

  mode_e state;
  logic  tick;
  logic  phase;
  logic  exit_set;

  // Leaving SET_MIN restarts the second: seconds clear and prescaler restart
  // happen together in the cycle after the button press.
  assign exit_set = (state == MODE_SET_MIN) && btn_mode;

  tick_prescaler #(
    .CLK_HZ(CLK_HZ)
  ) u_prescaler (
    .clk  (clk),
    .rst  (rst),
    .clr  (sec_clr),
    .tick (tick),
    .phase(phase)
  );

  // Mode FSM with the registered seconds-clear pulse on exit to RUN.
  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= MODE_RUN;
      sec_clr <= 1'b0;
    end else begin
      sec_clr <= exit_set;
      if (btn_mode) begin
        case (state)
          MODE_RUN:    state <= MODE_SET_HR;
          MODE_SET_HR: state <= MODE_SET_MIN;
          default:     state <= MODE_RUN;
        endcase
      end
    end
  end

  // Counter enables; combinational so carries ripple within one cycle.
  // A mode press in the same cycle as an increment suppresses the increment.
  always_comb begin
    // NOTE: every output gets a default first so no path leaves it unassigned,
    // which would otherwise infer a latch.
    sec_en  = 1'b0;
    min_en  = 1'b0;
    hour_en = 1'b0;
    case (state)
      MODE_RUN: begin
        sec_en  = tick;
        min_en  = sec_carry;
        hour_en = min_carry;
      end
      MODE_SET_HR:  hour_en = btn_inc && !btn_mode;
      MODE_SET_MIN: min_en  = btn_inc && !btn_mode;
      default: ;
    endcase
  end

  // AM/PM flips when the hour advances from 11 to 12, in RUN or SET_HR.
  always_ff @(posedge clk) begin
    if (rst) begin
      pm <= 1'b0;
    end else if (hour_en && is_hour_11(hr_tens, hr_ones)) begin
      pm <= ~pm;
    end
  end

  assign mode      = state;
  assign blink_hr  = (state == MODE_SET_HR)  && phase;
  assign blink_min = (state == MODE_SET_MIN) && phase;

endmodule

// File: tb/tb_clock_ctrl_12h.sv
// Directed bench for clock_ctrl_12h with CLK_HZ=10. Each step drives inputs
// at the falling edge, pushes the expected outputs from a small reference
// model onto a scoreboard queue, and pops/compares shortly afterwards.
module tb_clock_ctrl_12h;

  localparam int CLK_HZ = 10;

  logic       clk = 1'b0;
  logic       rst;
  logic       btn_mode;
  logic       btn_inc;
  logic       sec_carry;
  logic       min_carry;
  logic [3:0] hr_tens;
  logic [3:0] hr_ones;
  logic       sec_en;
  logic       sec_clr;
  logic       min_en;
  logic       hour_en;
  logic       pm;
  logic [1:0] mode;
  logic       blink_hr;
  logic       blink_min;

  clock_ctrl_12h #(
    .CLK_HZ(CLK_HZ)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .btn_mode (btn_mode),
    .btn_inc  (btn_inc),
    .sec_carry(sec_carry),
    .min_carry(min_carry),
    .hr_tens  (hr_tens),
    .hr_ones  (hr_ones),
    .sec_en   (sec_en),
    .sec_clr  (sec_clr),
    .min_en   (min_en),
    .hour_en  (hour_en),
    .pm       (pm),
    .mode     (mode),
    .blink_hr (blink_hr),
    .blink_min(blink_min)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic       sec_en;
    logic       sec_clr;
    logic       min_en;
    logic       hour_en;
    logic       pm;
    logic [1:0] mode;
    logic       blink_hr;
    logic       blink_min;
  } obs_t;

  obs_t exp_q[$];
  int   vectors     = 0;
  int   miscompares = 0;

  // Reference model state (value in the cycle about to be driven).
  int         m_cnt;
  logic [1:0] m_mode;
  logic       m_pm;
  logic       m_clr;
  int         hour;   // external hour counter, 1..12
  obs_t       last;

  task automatic check_int(input string tag, input int got, input int want);
    vectors++;
    assert (got === want) else begin
      miscompares++;
      $error("FAIL %s: observed %0d expected %0d", tag, got, want);
    end
  endtask

  task automatic step(input logic b_mode, input logic b_inc, input logic sc,
                      input logic mc, input logic r, input string tag);
    obs_t e;
    obs_t got;
    logic tk;
    logic ph;
    @(negedge clk);
    rst       = r;
    btn_mode  = b_mode;
    btn_inc   = b_inc;
    sec_carry = sc;
    min_carry = mc;
    hr_tens   = 4'(hour / 10);
    hr_ones   = 4'(hour % 10);
    tk = (m_cnt == CLK_HZ - 1);
    ph = (m_cnt < CLK_HZ / 2);
    e = '0;
    e.sec_clr = m_clr;
    e.pm      = m_pm;
    e.mode    = m_mode;
    case (m_mode)
      2'b00: begin e.sec_en = tk; e.min_en = sc; e.hour_en = mc; end
      2'b01: begin e.hour_en = b_inc & ~b_mode; e.blink_hr = ph; end
      2'b10: begin e.min_en = b_inc & ~b_mode; e.blink_min = ph; end
      default: ;
    endcase
    exp_q.push_back(e);
    #1;
    got.sec_en    = sec_en;
    got.sec_clr   = sec_clr;
    got.min_en    = min_en;
    got.hour_en   = hour_en;
    got.pm        = pm;
    got.mode      = mode;
    got.blink_hr  = blink_hr;
    got.blink_min = blink_min;
    e = exp_q.pop_front();
    vectors++;
    assert (got === e) else begin
      miscompares++;
      $error("FAIL %s: observed %b expected %b (sec_en,sec_clr,min_en,hour_en,pm,mode,blink_hr,blink_min)",
             tag, got, e);
    end
    last = got;
    // Advance the model across the coming rising edge.
    if (r) begin
      m_mode = 2'b00;
      m_pm   = 1'b0;
      m_clr  = 1'b0;
      m_cnt  = 0;
    end else begin
      m_cnt = m_clr ? 0 : ((m_cnt == CLK_HZ - 1) ? 0 : m_cnt + 1);
      if (e.hour_en && hour == 11) m_pm = ~m_pm;
      m_clr = (m_mode == 2'b10) && b_mode;
      if (b_mode) m_mode = (m_mode == 2'b00) ? 2'b01 : (m_mode == 2'b01) ? 2'b10 : 2'b00;
    end
    if (e.hour_en) hour = (hour == 12) ? 1 : hour + 1;
  endtask

  task automatic idle(input string tag);
    step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, tag);
  endtask

  // Idle until the next driven cycle is the tick cycle.
  task automatic run_to_tick(input string tag);
    for (int i = 0; i < CLK_HZ && m_cnt != CLK_HZ - 1; i++) idle(tag);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    int first;
    int hour_pulses;
    int sec_pulses;
    int last_toggle;
    int clr_extra;
    logic prev_blink;

    rst = 1'b1; btn_mode = 1'b0; btn_inc = 1'b0; sec_carry = 1'b0; min_carry = 1'b0;
    hour = 10;
    hr_tens = 4'd1; hr_ones = 4'd0;
    repeat (2) @(posedge clk);
    m_mode = 2'b00; m_pm = 1'b0; m_clr = 1'b0; m_cnt = 0;

    // 1: reset state and first tick 10 cycles after release, one cycle wide
    first = 0;
    for (int i = 1; i <= 20 && first == 0; i++) begin
      idle("t1_idle");
      if (i == 1) begin
        check_int("t1_reset_mode", int'(last.mode), 0);
        check_int("t1_reset_pm", int'(last.pm), 0);
        check_int("t1_reset_enables",
                  int'({last.sec_en, last.min_en, last.hour_en, last.sec_clr}), 0);
        check_int("t1_reset_blink", int'({last.blink_hr, last.blink_min}), 0);
      end
      if (last.sec_en) first = i;
    end
    check_int("t1_first_tick_cycle", first, 10);
    idle("t1_after_tick");
    check_int("t1_tick_width", int'(last.sec_en), 0);

    // 2: carry ripple in the tick cycle, then a tick without seconds carry
    run_to_tick("t2_wait");
    step(1'b0, 1'b0, 1'b1, 1'b1, 1'b0, "t2_ripple");
    check_int("t2_ripple_all", int'({last.sec_en, last.min_en, last.hour_en}), 7);
    run_to_tick("t2_wait2");
    idle("t2_no_carry");
    check_int("t2_tick_sec_en", int'(last.sec_en), 1);
    check_int("t2_no_carry_min_en", int'(last.min_en), 0);

    // 3: AM->PM at 11->12 via SET_HR increment; 12->01 leaves pm alone
    step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, "t3_enter_set_hr");
    idle("t3_in_set_hr");
    check_int("t3_mode_set_hr", int'(last.mode), 1);
    step(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, "t3_inc_at_11");
    check_int("t3_hour_en_at_11", int'(last.hour_en), 1);
    check_int("t3_pm_before", int'(last.pm), 0);
    idle("t3_after_11");
    check_int("t3_pm_after_11", int'(last.pm), 1);
    step(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, "t3_inc_at_12");
    check_int("t3_hour_en_at_12", int'(last.hour_en), 1);
    idle("t3_after_12");
    check_int("t3_pm_after_12", int'(last.pm), 1);

    // 4: three increments in SET_HR, no seconds, blink every 5 cycles
    hour_pulses = 0; sec_pulses = 0; last_toggle = -1; prev_blink = last.blink_hr;
    for (int i = 0; i < 24; i++) begin
      step(1'b0, (i % 8 == 2), 1'b0, 1'b0, 1'b0, "t4_set_hr");
      hour_pulses += int'(last.hour_en);
      sec_pulses  += int'(last.sec_en);
      if (last.blink_hr != prev_blink) begin
        if (last_toggle >= 0) check_int("t4_blink_spacing", i - last_toggle, 5);
        last_toggle = i;
      end
      prev_blink = last.blink_hr;
    end
    check_int("t4_hour_pulses", hour_pulses, 3);
    check_int("t4_sec_pulses", sec_pulses, 0);
    step(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, "t4_mode_and_inc");
    check_int("t4_inc_ignored", int'(last.hour_en), 0);
    idle("t4_in_set_min");
    check_int("t4_mode_set_min", int'(last.mode), 2);

    // 5: SET_MIN ignores min_carry for hours; exit pulses sec_clr, restarts tick
    step(1'b0, 1'b1, 1'b0, 1'b1, 1'b0, "t5_inc_min");
    check_int("t5_min_en", int'(last.min_en), 1);
    check_int("t5_hour_en", int'(last.hour_en), 0);
    step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, "t5_exit");
    idle("t5_clr_cycle");
    check_int("t5_sec_clr", int'(last.sec_clr), 1);
    check_int("t5_mode_run", int'(last.mode), 0);
    first = 0; clr_extra = 0;
    for (int d = 1; d <= 20 && first == 0; d++) begin
      idle("t5_resume");
      clr_extra += int'(last.sec_clr);
      if (last.sec_en) first = d;
    end
    check_int("t5_first_tick_after_clr", first, 10);
    check_int("t5_sec_clr_width", clr_extra, 0);

    // 6: reset in SET_MIN with pm=1 returns to RUN/AM without a clear pulse
    step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, "t6_to_set_hr");
    step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, "t6_to_set_min");
    idle("t6_in_set_min");
    check_int("t6_pre_mode", int'(last.mode), 2);
    check_int("t6_pre_pm", int'(last.pm), 1);
    step(1'b1, 1'b0, 1'b0, 1'b0, 1'b1, "t6_rst");
    idle("t6_after_rst");
    check_int("t6_mode", int'(last.mode), 0);
    check_int("t6_pm", int'(last.pm), 0);
    check_int("t6_blink_min", int'(last.blink_min), 0);
    clr_extra = int'(last.sec_clr);
    for (int i = 0; i < 3; i++) begin
      idle("t6_settle");
      clr_extra += int'(last.sec_clr);
    end
    check_int("t6_no_sec_clr", clr_extra, 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
